flit_out_inf_mc: RTL and testbench
==================================

Name: flit_out_inf_mc

Overview:
- Multi-channel flit output interface at the output of the per-VC flit queues (FQ).
- Per VC: compares the flit timestamp against simulation time and produces a sticky ready bit.
- Round-robin arbiter with starvation override picks one ready VC per cycle for the downstream router and issues that VC's dequeue.
- Generalises the single-channel ready logic to NUM_VC channels with configurable time-difference width.

Parameters:
- NUM_VC, 4, number of virtual channels / flit queues served (1..16).
- TS_WIDTH, `TS_WIDTH, width of timestamp and sim_time.
- DIFF_WIDTH, 4, low-order bits used for time difference; 2 <= DIFF_WIDTH <= TS_WIDTH.
- STARVE_LIMIT, 15, consecutive ready-but-not-granted cycles before a VC gets priority override.
- VC_IDX_W, $clog2(NUM_VC) (min 1), width of VC index.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- sim_time  in  TS_WIDTH  current simulation time.
- flit_valid  in  NUM_VC  per-VC head flit present at FQ output.
- flit_timestamp  in  NUM_VC*TS_WIDTH  per-VC head timestamp; VC i occupies bits [i*TS_WIDTH +: TS_WIDTH].
- out_ready  in  1  downstream router accepts a flit this cycle.
- vc_ready  out  NUM_VC  per-VC ready (timestamp <= sim_time, or sticky).
- out_valid  out  1  at least one VC is ready.
- out_sel  out  VC_IDX_W  index of the selected VC; valid when out_valid.
- dequeue  out  NUM_VC  one-hot pop to the FQs; equals the grant when out_ready is high.
- starved  out  NUM_VC  per-VC wait counter has reached STARVE_LIMIT.

Behaviour:
- Per-VC readiness:
  - diff_i = sim_time[DIFF_WIDTH-1:0] - ts_i[DIFF_WIDTH-1:0], modulo 2^DIFF_WIDTH.
  - w_valid_i = flit_valid_i & ~diff_i[MSB].
  - vc_ready_i = w_valid_i | r_valid_i.
- Sticky r_valid_i:
  - On reset: 0.
  - If ~r_valid_i: r_valid_i <= w_valid_i & ~dequeue_i.
  - Else if dequeue_i or ~flit_valid_i: r_valid_i <= 0.
  - Otherwise hold.
  - This keeps ready high after the difference wraps (flit waiting > 2^(DIFF_WIDTH-1) steps).
  - Clearing on ~flit_valid is new behaviour: a queue flush drops stickiness.
- Arbitration (combinational, zero latency):
  - req = vc_ready.
  - If any req_i & starved_i: grant the lowest such index.
  - Else: round-robin from rr_ptr upward, wrapping NUM_VC-1 -> 0.
  - out_valid = |req.
  - out_sel = granted index; 0 when ~out_valid.
  - dequeue = onehot(out_sel) & {NUM_VC{out_valid & out_ready}}.
- rr_ptr:
  - Reset 0.
  - Updates only on an accepted transfer (out_valid & out_ready): rr_ptr <= (out_sel+1) mod NUM_VC.
  - Updates on starvation-override grants as well.
- Wait counters (per VC, width $clog2(STARVE_LIMIT+1)):
  - Reset 0.
  - Clear when dequeue_i or ~vc_ready_i.
  - Increment when vc_ready_i & ~dequeue_i, saturating at STARVE_LIMIT.
  - starved_i = (wait_i == STARVE_LIMIT).
- Reset values: all registers 0. While reset is high, outputs derive combinationally from inputs with r_valid = 0. The bench checks outputs only after reset deasserts.
- Boundary conditions:
  - diff == 2^(DIFF_WIDTH-1): treated as future, not ready.
  - diff == 0: ready.
  - out_ready low: no dequeue, rr_ptr holds, wait counters advance.
  - NUM_VC == 1: out_sel constant 0; arbiter degenerates to a pass-through.
  - Simultaneous dequeue and newly valid flit on the same VC: r_valid stays 0 and the next flit is re-evaluated combinationally.
  - Reset mid-transfer: all sticky, pointer and counter state cleared next edge.

Decomposition:
- Shared package/const.v:
  - TS_WIDTH.
  - Default DIFF_WIDTH.
  - A clog2 macro/function for VC_IDX_W.
- Natural sub-module: flit_ts_ready, instantiated NUM_VC times. Holds the diff, w_valid, r_valid and wait counter for one VC.
- The arbiter and rr_ptr stay in the top module.

Test Plan:
- Single VC ready:
  - NUM_VC=4, DIFF_WIDTH=4, sim_time=5, VC2 valid ts=5, out_ready=1.
  - Expect vc_ready=4'b0100, out_sel=2, dequeue=4'b0100 in the same cycle, rr_ptr->3.
- Future flit:
  - VC0 ts=9, sim_time=5 (diff=12, MSB=1).
  - Expect vc_ready[0]=0, out_valid=0, no dequeue.
- Sticky across wrap:
  - VC1 ts=0 ready at sim_time=0, out_ready=0.
  - Advance sim_time to 8 (diff MSB=1).
  - Expect vc_ready[1] still 1.
  - Drop flit_valid[1]: expect vc_ready[1]=0 next cycle.
- Round-robin fairness:
  - All 4 VCs ready continuously, out_ready=1, rr_ptr=0.
  - Expect grant sequence 0,1,2,3,0.
- Starvation override:
  - STARVE_LIMIT=3, out_ready=0 for 3 cycles with VC3 ready.
  - Expect starved[3]=1.
  - Then out_ready=1 with rr_ptr=0 and VC0 ready: expect out_sel=3.
- Reset mid-operation:
  - Assert reset with r_valid set and wait counters nonzero.
  - Expect all r_valid, wait and rr_ptr at 0 after one edge, and starved=0.

Source files
------------

// File: rtl/flit_out_inf_mc_pkg.sv
// Shared constants for the multi-channel flit output interface.
//   FLIT_TS_WIDTH   : width of flit timestamps and simulation time
//   FLIT_DIFF_WIDTH : default number of low-order bits used for the time difference
//   clog2_min1()    : index width helper that never returns less than 1
package flit_out_inf_mc_pkg;

  localparam int FLIT_TS_WIDTH   = 16;
  localparam int FLIT_DIFF_WIDTH = 4;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/flit_out_inf_mc_ts_ready.sv
// Per-VC readiness tracker (flit_ts_ready).
// Compares the head flit timestamp against simulation time using a modulo
// difference of the low DIFF_WIDTH bits, keeps a sticky ready bit so a flit
// that has waited longer than half the difference range stays ready, and
// counts consecutive ready-but-not-dequeued cycles for starvation detection.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   sim_time         : current simulation time
//   timestamp        : head flit timestamp of this VC
//   flit_valid       : head flit present
//   dequeue          : this VC is popped this cycle
//   vc_ready         : flit is due (or sticky ready)
//   starved          : wait counter has reached STARVE_LIMIT
module flit_ts_ready
  import flit_out_inf_mc_pkg::*;
#(
  parameter int TS_WIDTH     = FLIT_TS_WIDTH,
  parameter int DIFF_WIDTH   = FLIT_DIFF_WIDTH,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [TS_WIDTH-1:0] sim_time,
  input  logic [TS_WIDTH-1:0] timestamp,
  input  logic                flit_valid,
  input  logic                dequeue,
  output logic                vc_ready,
  output logic                starved
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == LIMIT) ? v : v + WAIT_W'(1);
  endfunction

  logic [DIFF_WIDTH-1:0] diff;
  logic                  w_valid;
  logic                  r_valid;
  logic [WAIT_W-1:0]     wait_cnt;

  // Only the low bits take part in the comparison.
  if (DIFF_WIDTH < TS_WIDTH) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{sim_time[TS_WIDTH-1:DIFF_WIDTH], timestamp[TS_WIDTH-1:DIFF_WIDTH]};
  end

  // Modulo difference; a set MSB means the flit lies in the future.
  assign diff    = sim_time[DIFF_WIDTH-1:0] - timestamp[DIFF_WIDTH-1:0];
  assign w_valid = flit_valid & ~diff[DIFF_WIDTH-1];

  // Sticky state is masked while reset is held so outputs follow inputs only.
  assign vc_ready = w_valid | (r_valid & ~reset);
  assign starved  = (wait_cnt == LIMIT);

  // Stage boundary: sticky ready and wait counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (!r_valid)
        r_valid <= w_valid & ~dequeue;
      else if (dequeue || !flit_valid)
        r_valid <= 1'b0;

      if (dequeue || !vc_ready)
        wait_cnt <= '0;
      else
        wait_cnt <= sat_inc(wait_cnt);
    end
  end

endmodule

// File: rtl/flit_out_inf_mc.sv
// Multi-channel flit output interface.
// Each VC gets a timestamp readiness tracker; a combinational round-robin
// arbiter with starvation override picks one ready VC per cycle, and the
// chosen VC is dequeued when the downstream router accepts.
// Ports:
//   clock, reset    : clock, synchronous active-high reset
//   sim_time        : current simulation time
//   flit_valid      : per-VC head flit present
//   flit_timestamp  : per-VC head timestamps, VC i at [i*TS_WIDTH +: TS_WIDTH]
//   out_ready       : downstream accepts a flit this cycle
//   vc_ready        : per-VC ready
//   out_valid       : some VC is ready
//   out_sel         : selected VC index (0 when nothing is ready)
//   dequeue         : one-hot pop, non-zero only on an accepted transfer
//   starved         : per-VC starvation flag
module flit_out_inf_mc
  import flit_out_inf_mc_pkg::*;
#(
  parameter int NUM_VC       = 4,
  parameter int TS_WIDTH     = FLIT_TS_WIDTH,
  parameter int DIFF_WIDTH   = FLIT_DIFF_WIDTH,
  parameter int STARVE_LIMIT = 15,
  parameter int VC_IDX_W     = clog2_min1(NUM_VC)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [TS_WIDTH-1:0]        sim_time,
  input  logic [NUM_VC-1:0]          flit_valid,
  input  logic [NUM_VC*TS_WIDTH-1:0] flit_timestamp,
  input  logic                       out_ready,
  output logic [NUM_VC-1:0]          vc_ready,
  output logic                       out_valid,
  output logic [VC_IDX_W-1:0]        out_sel,
  output logic [NUM_VC-1:0]          dequeue,
  output logic [NUM_VC-1:0]          starved
);

  logic [VC_IDX_W-1:0] rr_ptr;
  logic [VC_IDX_W-1:0] grant;
  logic                xfer;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    flit_ts_ready #(
      .TS_WIDTH    (TS_WIDTH),
      .DIFF_WIDTH  (DIFF_WIDTH),
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_ready (
      .clock     (clock),
      .reset     (reset),
      .sim_time  (sim_time),
      .timestamp (flit_timestamp[i*TS_WIDTH +: TS_WIDTH]),
      .flit_valid(flit_valid[i]),
      .dequeue   (dequeue[i]),
      .vc_ready  (vc_ready[i]),
      .starved   (starved[i])
    );
  end

  // Priority: lowest starved requester, then first requester at or above
  // rr_ptr, then the lowest requester overall (the wrap-around case).
  always_comb begin
    logic [VC_IDX_W-1:0] starve_idx;
    logic [VC_IDX_W-1:0] hi_idx;
    logic [VC_IDX_W-1:0] lo_idx;
    logic                starve_found;
    logic                hi_found;
    starve_idx   = '0;
    hi_idx       = '0;
    lo_idx       = '0;
    starve_found = 1'b0;
    hi_found     = 1'b0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (vc_ready[i] && starved[i]) begin
        starve_idx   = VC_IDX_W'(i);
        starve_found = 1'b1;
      end
      if (vc_ready[i] && (VC_IDX_W'(i) >= rr_ptr)) begin
        hi_idx   = VC_IDX_W'(i);
        hi_found = 1'b1;
      end
      if (vc_ready[i])
        lo_idx = VC_IDX_W'(i);
    end
    if (starve_found)
      grant = starve_idx;
    else if (hi_found)
      grant = hi_idx;
    else
      grant = lo_idx;
  end

  assign out_valid = |vc_ready;
  assign out_sel   = out_valid ? grant : '0;
  assign xfer      = out_valid & out_ready;

  always_comb begin
    dequeue = '0;
    for (int i = 0; i < NUM_VC; i++)
      dequeue[i] = xfer && (out_sel == VC_IDX_W'(i));
  end

  // Stage boundary: round-robin pointer, advanced past every accepted grant.
  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (xfer)
      rr_ptr <= (int'(out_sel) == NUM_VC - 1) ? '0 : out_sel + VC_IDX_W'(1);
  end

endmodule

// File: tb/tb_flit_out_inf_mc.sv
module tb_flit_out_inf_mc;

  localparam int NV = 4;
  localparam int TW = 16;

  logic          clock;
  logic          reset;
  logic [TW-1:0] sim_time;
  logic [NV-1:0] flit_valid;
  logic [NV*TW-1:0] flit_timestamp;
  logic          out_ready;
  logic [NV-1:0] vc_ready;
  logic          out_valid;
  logic [1:0]    out_sel;
  logic [NV-1:0] dequeue;
  logic [NV-1:0] starved;

  flit_out_inf_mc #(
    .NUM_VC      (NV),
    .TS_WIDTH    (TW),
    .DIFF_WIDTH  (4),
    .STARVE_LIMIT(3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .sim_time      (sim_time),
    .flit_valid    (flit_valid),
    .flit_timestamp(flit_timestamp),
    .out_ready     (out_ready),
    .vc_ready      (vc_ready),
    .out_valid     (out_valid),
    .out_sel       (out_sel),
    .dequeue       (dequeue),
    .starved       (starved)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [3:0] vr;
    logic       ov;
    logic [1:0] sel;
    logic [3:0] deq;
    logic [3:0] st;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%b required=%b", nm, fld, act, req);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "vc_ready",  vc_ready,          e.vr);
      cmp(e.name, "out_valid", {3'b0, out_valid}, {3'b0, e.ov});
      cmp(e.name, "out_sel",   {2'b0, out_sel},   {2'b0, e.sel});
      cmp(e.name, "dequeue",   dequeue,           e.deq);
      cmp(e.name, "starved",   starved,           e.st);
    end
  end

  task automatic step(input string nm, input bit chk, input logic [TW-1:0] t,
                      input logic [3:0] fv, input logic [TW-1:0] ts, input logic ordy,
                      input logic [3:0] vr, input logic ov, input logic [1:0] sel,
                      input logic [3:0] deq, input logic [3:0] st);
    exp_t e;
    sim_time       = t;
    flit_valid     = fv;
    flit_timestamp = {NV{ts}};
    out_ready      = ordy;
    if (chk) begin
      e.name = nm; e.vr = vr; e.ov = ov; e.sel = sel; e.deq = deq; e.st = st;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    sim_time = '0; flit_valid = '0; flit_timestamp = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    //    name       chk t   fv      ts ordy vr      ov sel deq     st
    step("rst_state", 1, 0,  4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    step("single",    1, 5,  4'b0100, 5, 1, 4'b0100, 1, 2, 4'b0100, 4'b0000);
    // Round-robin with all VCs ready, starting from rr_ptr=3.
    step("rr_a",      1, 5,  4'b1111, 5, 1, 4'b1111, 1, 3, 4'b1000, 4'b0000);
    step("rr_b",      1, 5,  4'b1111, 5, 1, 4'b1111, 1, 0, 4'b0001, 4'b0000);
    step("rr_c",      1, 5,  4'b1111, 5, 1, 4'b1111, 1, 1, 4'b0010, 4'b0000);
    step("rr_d",      1, 5,  4'b1111, 5, 1, 4'b1111, 1, 2, 4'b0100, 4'b0100);
    step("rr_e",      1, 5,  4'b1111, 5, 1, 4'b1111, 1, 3, 4'b1000, 4'b1000);
    step("rr_f",      1, 5,  4'b1111, 5, 1, 4'b1111, 1, 0, 4'b0001, 4'b0001);
    // Reset with sticky bits, wait counters and pointer all non-zero.
    reset = 1'b1;
    step("in_reset",  0, 5,  4'b1111, 5, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    reset = 1'b0;
    step("post_rst1", 1, 5,  4'b0000, 5, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    step("post_rst2", 1, 5,  4'b1111, 5, 1, 4'b1111, 1, 0, 4'b0001, 4'b0000);
    // Flush: sticky ready survives one cycle, then drops.
    step("flush1",    1, 5,  4'b0000, 5, 0, 4'b1110, 1, 1, 4'b0000, 4'b0000);
    step("flush2",    1, 5,  4'b0000, 5, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    // Timestamp boundaries on VC0.
    step("future",    1, 5,  4'b0001, 9, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    step("diff8",     1, 13, 4'b0001, 5, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    step("diff7",     1, 12, 4'b0001, 5, 1, 4'b0001, 1, 0, 4'b0001, 4'b0000);
    // Sticky across wrap on VC1 with out_ready low.
    step("stk_0",     1, 0,  4'b0010, 0, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000);
    step("stk_8",     1, 8,  4'b0010, 0, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000);
    step("stk_8b",    1, 8,  4'b0010, 0, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000);
    step("stk_9",     1, 9,  4'b0010, 0, 0, 4'b0010, 1, 1, 4'b0000, 4'b0010);
    step("stk_drop",  1, 9,  4'b0000, 0, 0, 4'b0010, 1, 1, 4'b0000, 4'b0010);
    step("stk_gone",  1, 9,  4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0010);
    step("vc3_xfer",  1, 5,  4'b1000, 5, 1, 4'b1000, 1, 3, 4'b1000, 4'b0000);
    // Starvation override on VC3 against rr_ptr=0 and VC0 ready.
    step("stv_1",     1, 5,  4'b1000, 5, 0, 4'b1000, 1, 3, 4'b0000, 4'b0000);
    step("stv_2",     1, 5,  4'b1000, 5, 0, 4'b1000, 1, 3, 4'b0000, 4'b0000);
    step("stv_3",     1, 5,  4'b1000, 5, 0, 4'b1000, 1, 3, 4'b0000, 4'b0000);
    step("stv_ovr",   1, 5,  4'b1001, 5, 1, 4'b1001, 1, 3, 4'b1000, 4'b1000);
    step("stv_after", 1, 5,  4'b1001, 5, 1, 4'b1001, 1, 0, 4'b0001, 4'b0000);

    @(negedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
